// File: rtl/dsp_acc_64_if.sv
// dsp_acc_64_if: job control, beat input and result handshake bundle for dsp_acc_64
interface dsp_acc_64_if #(parameter int ACC_LEN_W = 16);
  logic                 start;
  logic [ACC_LEN_W-1:0] len;
  logic                 active_chain;
  logic [3:0]           ce;
  logic [63:0]          in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [63:0]          out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0]           ovf;
  logic                 busy;
  modport master (
    output start, len, active_chain, ce, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, ovf, busy
  );
  modport slave (
    input  start, len, active_chain, ce, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, ovf, busy
  );
endinterface

// File: rtl/dsp_acc_64.sv
// dsp_acc_64: 8/8/16/32 split or 64-bit chained beat accumulator; DSP_ACC_SAT_EN enables saturating lanes
module dsp_acc_64 #(parameter int ACC_LEN_W = 16) (
  input logic       CLK,
  input logic       ARESETN,
  input logic       SCLR,
  dsp_acc_64_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t               state_q, state_d;
  logic [ACC_LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic                 chain_q, chain_d;
  logic [3:0]           ce_q, ce_d;
  logic [63:0]          acc_q, acc_d, out_q, out_d, split, chained, sum, mask;
  logic                 in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
  logic                 last;
  assign mask = {{32{ce_q[3]}}, {16{ce_q[2]}}, {8{ce_q[1]}}, {8{ce_q[0]}}};
  assign sum  = chain_q ? (&ce_q ? chained : 64'd0) : split & mask;
  assign last = cnt_q == len_q - ACC_LEN_W'(1);
`ifdef DSP_ACC_SAT_EN
  logic [8:0]  s0, s1;
  logic [16:0] s2;
  logic [32:0] s3;
  logic [64:0] sc;
  logic [3:0]  ovf_q, ovf_d, ovf_beat;
  // sign-extended lane adds; a carry/sign disagreement means the lane clamps to its signed limit
  always_comb begin
    s0 = {acc_q[7], acc_q[7:0]} + {bus.in_data[7], bus.in_data[7:0]};
    s1 = {acc_q[15], acc_q[15:8]} + {bus.in_data[15], bus.in_data[15:8]};
    s2 = {acc_q[31], acc_q[31:16]} + {bus.in_data[31], bus.in_data[31:16]};
    s3 = {acc_q[63], acc_q[63:32]} + {bus.in_data[63], bus.in_data[63:32]};
    sc = {acc_q[63], acc_q} + {bus.in_data[63], bus.in_data};
    split = {(s3[32] ^ s3[31]) ? {s3[32], {31{~s3[32]}}} : s3[31:0],
             (s2[16] ^ s2[15]) ? {s2[16], {15{~s2[16]}}} : s2[15:0],
             (s1[8] ^ s1[7]) ? {s1[8], {7{~s1[8]}}} : s1[7:0],
             (s0[8] ^ s0[7]) ? {s0[8], {7{~s0[8]}}} : s0[7:0]};
    chained = (sc[64] ^ sc[63]) ? {sc[64], {63{~sc[64]}}} : sc[63:0];
    ovf_beat = chain_q ? {3'b000, &ce_q & (sc[64] ^ sc[63])}
                       : ce_q & {s3[32] ^ s3[31], s2[16] ^ s2[15], s1[8] ^ s1[7], s0[8] ^ s0[7]};
  end
  // sticky per-job overflow, cleared by SCLR and by a new job
  always_comb begin
    ovf_d = ovf_q;
    if (SCLR || (state_q == IDLE && bus.start)) ovf_d = 4'b0000;
    else if (state_q == ACC && bus.in_valid) ovf_d = ovf_q | ovf_beat;
  end
  // overflow flag register
  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) ovf_q <= 4'b0000;
    else ovf_q <= ovf_d;
  end
  assign bus.ovf = ovf_q;
`else
  // wrapping lane adds: carries never cross lane boundaries
  always_comb begin
    split = {acc_q[63:32] + bus.in_data[63:32], acc_q[31:16] + bus.in_data[31:16],
             acc_q[15:8] + bus.in_data[15:8], acc_q[7:0] + bus.in_data[7:0]};
    chained = acc_q + bus.in_data;
  end
  assign bus.ovf = 4'b0000;
`endif
  // job sequencing: latch config on start, add beats in ACC, hold result in DONE
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    chain_d = chain_q;
    ce_d    = ce_q;
    acc_d   = acc_q;
    out_d   = out_q;
    if (SCLR) begin
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = 64'd0;
      out_d   = 64'd0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          state_d = ACC;
          len_d   = (bus.len == '0) ? ACC_LEN_W'(1) : bus.len;
          chain_d = bus.active_chain;
          ce_d    = bus.ce;
          cnt_d   = '0;
          acc_d   = 64'd0;
        end
        ACC: if (bus.in_valid) begin
          acc_d   = sum;
          cnt_d   = cnt_q + ACC_LEN_W'(1);
          out_d   = last ? sum : out_q;
          state_d = last ? DONE : ACC;
        end
        DONE: state_d = bus.out_ready ? IDLE : DONE;
        default: state_d = IDLE;
      endcase
    end
    in_ready_d  = state_d == ACC;
    out_valid_d = state_d == DONE;
    busy_d      = state_d != IDLE;
  end
  // state and registered outputs
  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      chain_q     <= 1'b0;
      ce_q        <= 4'b0000;
      acc_q       <= 64'd0;
      out_q       <= 64'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      chain_q     <= chain_d;
      ce_q        <= ce_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_dsp_acc_64.sv
// tb_dsp_acc_64: directed checks of dsp_acc_64 (expectations follow DSP_ACC_SAT_EN)
module tb_dsp_acc_64;
  logic CLK = 1'b0, ARESETN = 1'b0, SCLR = 1'b0;
  int n_cmp = 0, n_bad = 0;
  dsp_acc_64_if #(.ACC_LEN_W(16)) bus ();
  dsp_acc_64 #(.ACC_LEN_W(16)) dut (.CLK(CLK), .ARESETN(ARESETN), .SCLR(SCLR), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic do_start(input logic [15:0] l, input logic ch, input logic [3:0] c);
    bus.start = 1'b1; bus.len = l; bus.active_chain = ch; bus.ce = c;
    tick();
    bus.start = 1'b0; bus.active_chain = ~ch; bus.ce = ~c;
  endtask
  task automatic beat(input logic [63:0] d);
    bus.in_valid = 1'b1; bus.in_data = d;
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic accept();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask
  initial begin
    logic [63:0] hold;
    bus.start = 0; bus.len = 0; bus.active_chain = 0; bus.ce = 0;
    bus.in_data = 0; bus.in_valid = 0; bus.out_ready = 0;
    #3;
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_flags", {60'd0, bus.out_valid, bus.in_ready, bus.busy, |bus.ovf}, 64'd0);
    @(negedge CLK); ARESETN = 1'b1;
    tick();
    do_start(16'd3, 1'b0, 4'b1111);
    chk("split_in_ready", {63'd0, bus.in_ready}, 64'd1);
    beat(64'h00000002_0003_04_05);
    beat(64'h00000002_0003_04_05);
    chk("split_not_done", {63'd0, bus.out_valid}, 64'd0);
    beat(64'h00000002_0003_04_05);
    chk("split_out_valid", {62'd0, bus.out_valid, bus.in_ready}, 64'd2);
    chk("split_sum", bus.out_data, 64'h00000006_0009_0C_0F);
    chk("split_ovf", {60'd0, bus.ovf}, 64'd0);
    accept();
    chk("split_idle", {62'd0, bus.out_valid, bus.busy}, 64'd0);
    do_start(16'd2, 1'b1, 4'b1111);
    beat(64'd1000);
    beat(64'hFFFFFFFF_FFFFFF9C);
    chk("chain_sum", bus.out_data, 64'd900);
    accept();
    do_start(16'd2, 1'b0, 4'b1111);
    beat(64'h70);
    beat(64'h70);
`ifdef DSP_ACC_SAT_EN
    chk("lane0_ovf_data", bus.out_data, 64'h7F);
    chk("lane0_ovf_flag", {60'd0, bus.ovf}, 64'd1);
`else
    chk("lane0_ovf_data", bus.out_data, 64'hE0);
    chk("lane0_ovf_flag", {60'd0, bus.ovf}, 64'd0);
`endif
    accept();
    do_start(16'd1, 1'b0, 4'b0101);
    beat(64'hFFFFFFFF_FFFF_FF_FF);
    chk("ce_mask", bus.out_data, 64'h00000000_FFFF_00_FF);
    accept();
    do_start(16'd1, 1'b1, 4'b0111);
    beat(64'd5);
    chk("chain_bad_ce", bus.out_data, 64'd0);
    accept();
    do_start(16'd0, 1'b0, 4'b1111);
    beat(64'h42);
    chk("len0_done", {63'd0, bus.out_valid}, 64'd1);
    chk("len0_data", bus.out_data, 64'h42);
    accept();
    do_start(16'd1, 1'b0, 4'b1111);
    beat(64'h1234);
    hold = bus.out_data;
    chk("bp_data", hold, 64'h1234);
    for (int i = 0; i < 5; i++) begin
      bus.start = (i == 2);
      bus.in_valid = 1'b1; bus.in_data = 64'hFF;
      tick();
      chk("bp_stable", {bus.out_data, 2'b00} >> 2, hold);
      chk("bp_hs", {62'd0, bus.out_valid, bus.in_ready}, 64'd2);
    end
    bus.in_valid = 1'b0;
    bus.start = 1'b1;
    accept();
    bus.start = 1'b0;
    chk("bp_release", {61'd0, bus.out_valid, bus.in_ready, bus.busy}, 64'd0);
    tick();
    chk("bp_start_ignored", {63'd0, bus.in_ready}, 64'd0);
    do_start(16'd4, 1'b0, 4'b1111);
    beat(64'h11111111_1111_11_11);
    beat(64'h22222222_2222_22_22);
    SCLR = 1'b1; bus.start = 1'b1;
    tick();
    SCLR = 1'b0; bus.start = 1'b0;
    chk("sclr_flags", {61'd0, bus.out_valid, bus.in_ready, bus.busy}, 64'd0);
    chk("sclr_data", bus.out_data, 64'd0);
    do_start(16'd1, 1'b0, 4'b1111);
    beat(64'h1);
    chk("post_sclr", bus.out_data, 64'h1);
    accept();
    do_start(16'd3, 1'b0, 4'b1111);
    beat(64'h5);
    #2 ARESETN = 1'b0;
    #1;
    chk("arst_flags", {60'd0, bus.out_valid, bus.in_ready, bus.busy, |bus.ovf}, 64'd0);
    chk("arst_data", bus.out_data, 64'd0);
    @(negedge CLK); ARESETN = 1'b1;
    tick();
    chk("arst_idle", {63'd0, bus.busy}, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dsp_acc_64.md
# dsp_acc_64

Multi-precision accumulator that sits directly downstream of the 64-bit DSP MAC/multiplier stage and consumes its packed product word `P`. It sums a programmed number of product beats per lane group (8/8/16/32-bit split lanes, or one 64-bit chained lane) and presents the packed result to the write-back path over a valid/ready handshake. Lane layout and enable mask match the MAC stage, so both are driven by the same precision control.

## Interface
- `ACC_LEN_W`, 16, width of the beat-count field.
- `CLK` in 1, rising-edge clock.
- `ARESETN` in 1, asynchronous active-low reset.
- `SCLR` in 1, synchronous clear, active high.
- `start` in 1, begins one accumulation job (sampled in IDLE only).
- `len` in `ACC_LEN_W`, number of beats per job; 0 treated as 1.
- `active_chain` in 1, 1 = single 64-bit lane; 0 = split lanes.
- `ce` in 4, lane enable mask: bit0 `[7:0]`, bit1 `[15:8]`, bit2 `[31:16]`, bit3 `[63:32]`.
- `in_data` in 64, packed signed products from the MAC stage.
- `in_valid` in 1, `in_data` valid.
- `in_ready` out 1, accumulator accepts a beat.
- `out_data` out 64, packed accumulated result.
- `out_valid` out 1, result valid.
- `out_ready` in 1, consumer accepts result.
- `ovf` out 4, per-lane overflow flags for the current result; bit0 is the chained-lane flag when `active_chain`=1.
- `busy` out 1, high in ACC and DONE.

## Operation
- States: IDLE, ACC, DONE.
- IDLE: `in_ready`=0, `out_valid`=0. When `start`=1: latch `len` (0→1), `active_chain`, `ce`; clear accumulators, beat counter and `ovf`; go to ACC.
- ACC: `in_ready`=1. Each `in_valid && in_ready` beat adds the lanes as signed two's complement at lane width: 8, 8, 16, 32 bits; with `active_chain`=1, one 64-bit add.
- Lanes whose latched `ce` bit is 0 hold zero. They contribute zero to `out_data` and never set `ovf`. With `active_chain`=1 all four `ce` bits must be 1; otherwise the result is forced to 0.
- On the beat where counter == latched `len`−1: register the final sum into `out_data` and go to DONE.
- DONE: `out_valid`=1 and `in_ready`=0. `out_data` and `ovf` are held stable until `out_ready`=1, then go to IDLE. `start` is ignored in ACC and DONE, including on the cycle the result is accepted.
- `in_valid` with `in_ready`=0 is not consumed. The upstream stage holds its data.
- `SCLR`=1 in any state: go to IDLE the next cycle; clear accumulators, counter, `out_data`, `ovf`, `out_valid`. `SCLR` has priority over `start` and over handshakes.
- Changes on `ce`/`active_chain` during a job have no effect; the latched copies are used.

## Timing
- Reset (`ARESETN`=0, asynchronous): state IDLE; `out_data`=0, `out_valid`=0, `in_ready`=0, `ovf`=0, `busy`=0.
- `start` in cycle t → `in_ready`=1 from t+1.
- Last beat accepted in cycle t → `out_valid`=1 and `out_data` valid from t+1.
- Result accepted in cycle t → IDLE at t+1; earliest next `start` is sampled at t+1.
- Throughput: one beat per cycle in ACC. Job cost is `len` + 2 cycles plus output stall.
- Reset or `SCLR` mid-job discards partial sums; no output is produced.

## Configuration
- `DSP_ACC_SAT_EN` defined: each lane add saturates to the lane's signed max/min. The lane's `ovf` bit is set sticky for the job when clamping occurs.
- `DSP_ACC_SAT_EN` undefined: lane adds wrap modulo 2^width. `ovf` is tied to 0 and the saturation logic is not built.

## Test plan
- Split mode, `ce`=4'b1111, `len`=3, beats `in_data`=64'h00000002_0003_04_05 ×3 → `out_data`=64'h00000006_0009_0C_0F, `ovf`=0. `out_valid` rises the cycle after the 3rd beat.
- Chain mode, `ce`=4'b1111, `len`=2, beats 64'd1000 and 64'hFFFFFFFF_FFFFFF9C (−100) → `out_data`=64'd900.
- Lane 0 overflow, `len`=2, lane0 = 8'h70 twice → with `DSP_ACC_SAT_EN`: lane0 = 8'h7F, `ovf[0]`=1. Without it: lane0 = 8'hE0, `ovf`=0.
- `ce`=4'b0101, `len`=1, `in_data`=64'hFFFFFFFF_FFFF_FF_FF → `out_data`=64'h00000000_FFFF_00_FF.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `out_data` stable, `in_ready`=0, a `start` pulse is ignored. Raising `out_ready` → IDLE the next cycle.
- `SCLR` after the 2nd of 4 beats, then a new job with `len`=1, beat 64'h1 → `out_data`=64'h1, with no residue from the aborted job. `ARESETN` low mid-ACC → all outputs 0 immediately.
